// File: rtl/mem_boot_ctrl_if.sv
// mem_boot_ctrl_if: host word stream into the boot controller.
// A word moves on a rising edge when s_valid and s_ready are both high.
interface mem_boot_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl: loads host words into data then instruction BRAM,
// then releases the rv32i core until halt or cycle budget expiry.
module mem_boot_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [10:0]           d_word_cnt,
    input  logic [10:0]           i_word_cnt,
    input  logic [15:0]           run_cycles,
    input  logic                  halt,
    mem_boot_ctrl_if.slave        host,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic [3:0]            d_w_byte_enb,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [3:0]            i_w_byte_enb,
    output logic                  d_bram_init_done,
    output logic                  core_rst,
    output logic                  pc_stall,
    output logic                  i_r_enb,
    output logic                  rd_enbl,
    output logic [2:0]            state,
    output logic [15:0]           cycles_run
);
    localparam int CNT_W = 11;
    localparam int IDX_W = $clog2(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_D = 3'd1,
        LOAD_I = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_nxt;
    logic             fin_q, fin_nxt;
    logic [CNT_W-1:0] d_cnt, i_cnt, cur_cnt, d_sat, i_sat;
    logic [15:0]      budget;
    logic [IDX_W-1:0] idx;
    logic             hs, last, sess_start;
    logic [ADDR_WIDTH-1:0] wr_addr;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : c;
    endfunction

    assign state      = state_q;
    assign d_sat      = sat_cnt(d_word_cnt);
    assign i_sat      = sat_cnt(i_word_cnt);
    assign cur_cnt    = (state_q == LOAD_I) ? i_cnt : d_cnt;
    assign hs         = host.s_valid & host.s_ready;
    assign last       = (CNT_W'(idx) == cur_cnt - CNT_W'(1));
    assign sess_start = start & (state_q == IDLE || state_q == DONE);
    assign wr_addr    = ADDR_WIDTH'({idx, 2'b00});

    // fin_q holds the last load phase for one extra cycle so the final
    // write strobe lands before the core leaves reset.
    always_comb begin
        state_nxt = state_q;
        fin_nxt   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (d_sat != '0)      state_nxt = LOAD_D;
                    else if (i_sat != '0) state_nxt = LOAD_I;
                    else                  state_nxt = RUN;
                end
            end
            LOAD_D: begin
                if (fin_q) state_nxt = RUN;
                else if (hs && last) begin
                    if (i_cnt != '0) state_nxt = LOAD_I;
                    else             fin_nxt   = 1'b1;
                end
            end
            LOAD_I: begin
                if (fin_q)           state_nxt = RUN;
                else if (hs && last) fin_nxt   = 1'b1;
            end
            RUN: begin
                if (halt || (budget != '0 && cycles_run == budget - 16'd1))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            fin_q            <= 1'b0;
            host.s_ready     <= 1'b0;
            d_w_addr         <= '0;
            d_w_dat          <= '0;
            d_w_enb          <= 1'b0;
            d_w_byte_enb     <= 4'h0;
            i_w_addr         <= '0;
            i_w_dat          <= '0;
            i_w_enb          <= 1'b0;
            i_w_byte_enb     <= 4'h0;
            d_bram_init_done <= 1'b0;
            core_rst         <= 1'b1;
            pc_stall         <= 1'b1;
            i_r_enb          <= 1'b0;
            rd_enbl          <= 1'b0;
            cycles_run       <= '0;
            d_cnt            <= '0;
            i_cnt            <= '0;
            budget           <= '0;
            idx              <= '0;
        end else begin
            state_q      <= state_nxt;
            fin_q        <= fin_nxt;
            host.s_ready <= (state_nxt == LOAD_D || state_nxt == LOAD_I)
                            && !fin_nxt;

            d_w_enb      <= hs && state_q == LOAD_D;
            d_w_byte_enb <= (hs && state_q == LOAD_D) ? 4'hF : 4'h0;
            i_w_enb      <= hs && state_q == LOAD_I;
            i_w_byte_enb <= (hs && state_q == LOAD_I) ? 4'hF : 4'h0;
            if (hs && state_q == LOAD_D) begin
                d_w_addr <= wr_addr;
                d_w_dat  <= host.s_data;
            end
            if (hs && state_q == LOAD_I) begin
                i_w_addr <= wr_addr;
                i_w_dat  <= host.s_data;
            end

            if (sess_start) begin
                d_cnt      <= d_sat;
                i_cnt      <= i_sat;
                budget     <= run_cycles;
                idx        <= '0;
                cycles_run <= '0;
            end else begin
                if (hs) idx <= last ? '0 : idx + IDX_W'(1);
                if (state_q == RUN && cycles_run != 16'hFFFF)
                    cycles_run <= cycles_run + 16'd1;
            end

            d_bram_init_done <= state_nxt == RUN || state_nxt == DONE;
            core_rst         <= !(state_nxt == RUN || state_nxt == DONE);
            pc_stall         <= state_nxt != RUN;
            i_r_enb          <= state_nxt == RUN;
            rd_enbl          <= state_nxt == RUN || state_nxt == DONE;
        end
    end
endmodule

// File: tb/tb_mem_boot_ctrl.sv
// tb_mem_boot_ctrl: directed sessions with a write scoreboard;
// expected BRAM writes are queued at handshake and popped on strobe.
module tb_mem_boot_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] d_word_cnt = '0;
    logic [10:0] i_word_cnt = '0;
    logic [15:0] run_cycles = '0;
    logic        halt = 1'b0;
    logic [11:0] d_w_addr, i_w_addr;
    logic [31:0] d_w_dat, i_w_dat;
    logic        d_w_enb, i_w_enb;
    logic [3:0]  d_w_byte_enb, i_w_byte_enb;
    logic        d_bram_init_done, core_rst, pc_stall, i_r_enb, rd_enbl;
    logic [2:0]  state;
    logic [15:0] cycles_run;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        iport;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int          d_strobes = 0;
    int          i_strobes = 0;
    logic [11:0] last_d_addr = '0;

    mem_boot_ctrl_if #(.DATA_WIDTH(32)) hif ();

    mem_boot_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .d_word_cnt(d_word_cnt), .i_word_cnt(i_word_cnt),
        .run_cycles(run_cycles), .halt(halt), .host(hif),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .d_w_byte_enb(d_w_byte_enb),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .i_w_byte_enb(i_w_byte_enb),
        .d_bram_init_done(d_bram_init_done), .core_rst(core_rst),
        .pc_stall(pc_stall), .i_r_enb(i_r_enb), .rd_enbl(rd_enbl),
        .state(state), .cycles_run(cycles_run)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d_w_enb || i_w_enb) begin
            wr_t e;
            check("single_strobe", 32'(d_w_enb & i_w_enb), 32'd0);
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe_port", 32'(i_w_enb), 32'(e.iport));
                if (i_w_enb) begin
                    i_strobes++;
                    check("i_addr", 32'(i_w_addr), 32'(e.addr));
                    check("i_data", i_w_dat, e.data);
                    check("i_byte_enb", 32'(i_w_byte_enb), 32'hF);
                end else begin
                    d_strobes++;
                    last_d_addr = d_w_addr;
                    check("d_addr", 32'(d_w_addr), 32'(e.addr));
                    check("d_data", d_w_dat, e.data);
                    check("d_byte_enb", 32'(d_w_byte_enb), 32'hF);
                end
            end
        end
    end

    task automatic begin_session(input int dc, input int ic, input int rc);
        d_word_cnt = 11'(dc);
        i_word_cnt = 11'(ic);
        run_cycles = 16'(rc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input string tag, input bit iport, input int n,
                          input logic [31:0] seed, input bit gap,
                          output int stalls);
        int got = 0;
        int guard = 0;
        stalls = 0;
        while (got < n && guard < 5000) begin
            hif.s_valid = 1'b1;
            hif.s_data  = seed + 32'(got);
            if (hif.s_ready) begin
                exp_q.push_back('{iport, 12'(got * 4), seed + 32'(got)});
                got++;
            end else begin
                stalls++;
            end
            @(negedge clk);
            guard++;
            if (gap) begin
                hif.s_valid = 1'b0;
                @(negedge clk);
            end
        end
        hif.s_valid = 1'b0;
        check(tag, 32'(got), 32'(n));
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s,
                              input int bound);
        int k = 0;
        while (state !== s && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_s_ready"}, 32'(hif.s_ready), 32'd0);
        check({tag, "_enb"}, 32'({d_w_enb, i_w_enb}), 32'd0);
        check({tag, "_byte_enb"}, 32'({d_w_byte_enb, i_w_byte_enb}), 32'd0);
        check({tag, "_addr"}, 32'({d_w_addr, i_w_addr}), 32'd0);
        check({tag, "_d_dat"}, d_w_dat, 32'd0);
        check({tag, "_i_dat"}, i_w_dat, 32'd0);
        check({tag, "_ctrl"},
              32'({d_bram_init_done, core_rst, pc_stall, i_r_enb, rd_enbl}),
              32'b01100);
        check({tag, "_cycles"}, 32'(cycles_run), 32'd0);
    endtask

    initial begin
        int st;
        int n;
        int snap_d;
        int snap_i;
        bit saw_ready;

        hif.s_valid = 1'b0;
        hif.s_data  = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // basic load and run
        begin_session(1, 9, 13);
        check("basic_load_d", 32'(state), 32'd1);
        check("basic_ready", 32'(hif.s_ready), 32'd1);
        stream("basic_d", 1'b0, 1, 32'h0000_0000, 1'b0, st);
        stream("basic_i", 1'b1, 9, 32'h0000_1000, 1'b0, st);
        check("basic_no_bubble", 32'(st), 32'd0);
        check("basic_ready_drop", 32'(hif.s_ready), 32'd0);
        check("basic_still_rst", 32'(core_rst), 32'd1);
        @(negedge clk);
        check("basic_run", 32'(state), 32'd3);
        check("basic_run_ctrl",
              32'({d_bram_init_done, core_rst, pc_stall, i_r_enb, rd_enbl}),
              32'b10011);
        n = 0;
        while (state === 3'd3 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("basic_run_len", 32'(n), 32'd13);
        check("basic_done", 32'(state), 32'd4);
        check("basic_cycles", 32'(cycles_run), 32'd13);
        check("basic_done_ctrl",
              32'({d_bram_init_done, core_rst, pc_stall, i_r_enb, rd_enbl}),
              32'b10101);
        check("basic_i_count", 32'(i_strobes), 32'd9);

        // gapped stream, started from DONE
        snap_d = d_strobes;
        begin_session(4, 0, 2);
        check("gap_load_d", 32'(state), 32'd1);
        check("gap_init_drop", 32'(d_bram_init_done), 32'd0);
        stream("gap_d", 1'b0, 4, 32'hA5A5_0000, 1'b1, st);
        wait_state("gap_done", 3'd4, 20);
        check("gap_strobes", 32'(d_strobes - snap_d), 32'd4);
        check("gap_cycles", 32'(cycles_run), 32'd2);
        check("gap_last_addr", 32'(last_d_addr), 32'hC);

        // zero counts
        saw_ready = 1'b0;
        begin_session(0, 0, 5);
        check("zero_run", 32'(state), 32'd3);
        n = 0;
        while (state !== 3'd4 && n < 50) begin
            if (hif.s_ready) saw_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        check("zero_no_ready", 32'(saw_ready), 32'd0);
        check("zero_cycles", 32'(cycles_run), 32'd5);

        // halt with an ignored start during RUN
        begin_session(1, 1, 0);
        stream("halt_d", 1'b0, 1, 32'hDEAD_0000, 1'b0, st);
        stream("halt_i", 1'b1, 1, 32'hBEEF_0000, 1'b0, st);
        wait_state("halt_run", 3'd3, 10);
        for (int k = 1; k <= 20; k++) begin
            if (k == 5) begin
                d_word_cnt = 11'd7;
                start = 1'b1;
            end
            if (k == 6) begin
                start = 1'b0;
                check("halt_start_ignored", 32'(state), 32'd3);
                check("halt_cycles_mid", 32'(cycles_run), 32'd5);
            end
            if (k == 20) begin
                check("halt_cycles_pre", 32'(cycles_run), 32'd19);
                halt = 1'b1;
            end
            @(negedge clk);
        end
        halt = 1'b0;
        check("halt_done", 32'(state), 32'd4);
        check("halt_cycles", 32'(cycles_run), 32'd20);
        check("halt_stall", 32'(pc_stall), 32'd1);

        // reset mid-load after 3 of 9 instruction words
        begin_session(0, 9, 0);
        check("rst_load_i", 32'(state), 32'd2);
        stream("rst_i", 1'b1, 3, 32'h1234_0000, 1'b0, st);
        hif.s_valid = 1'b1;
        hif.s_data  = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        hif.s_valid = 1'b0;
        check("rst_no_strobe", 32'(i_w_enb), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        begin_session(0, 2, 3);
        stream("reload_i", 1'b1, 2, 32'h5678_0000, 1'b0, st);
        wait_state("reload_done", 3'd4, 20);
        check("reload_cycles", 32'(cycles_run), 32'd3);

        // saturation of an oversize data count
        snap_d = d_strobes;
        snap_i = i_strobes;
        begin_session(1100, 1, 1);
        stream("sat_d", 1'b0, 1024, 32'h0BAD_0000, 1'b0, st);
        check("sat_load_i", 32'(state), 32'd2);
        check("sat_ready", 32'(hif.s_ready), 32'd1);
        stream("sat_i", 1'b1, 1, 32'hC0DE_0000, 1'b0, st);
        check("sat_i_no_bubble", 32'(st), 32'd0);
        wait_state("sat_done", 3'd4, 20);
        check("sat_d_strobes", 32'(d_strobes - snap_d), 32'd1024);
        check("sat_i_strobes", 32'(i_strobes - snap_i), 32'd1);
        check("sat_last_addr", 32'(last_d_addr), 32'hFFC);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_boot_ctrl.md
# mem_boot_ctrl

Boot and run sequencer for the single-core rv32i datapath. It takes a host word stream and writes it first into data BRAM, then into instruction BRAM. It then hands the data BRAM write port to the core via `d_bram_init_done`, releases the core and the PC, and stops the core on a halt request or when a cycle budget expires. In hardware it replaces the hand-sequenced load/execute procedure, and it sits between the host link (UART/JTAG bridge) and the `pc`, `bram32` and `register_file` control inputs.

## Interface
- `ADDR_WIDTH`, default 12: BRAM byte-address width.
- `DATA_WIDTH`, default 32: word width.
- `MAX_WORDS`, default 1024: words per BRAM.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `start  in  1`: one-cycle pulse that begins a session; honoured only in IDLE or DONE.
- `d_word_cnt  in  11`: data words to load; sampled on accepted `start`.
- `i_word_cnt  in  11`: instruction words to load; sampled on accepted `start`.
- `run_cycles  in  16`: execution budget in cycles; 0 means unlimited. Sampled on accepted `start`.
- `halt  in  1`: stop request from the core or host; honoured in RUN only.
- `s_valid  in  1`: host word valid.
- `s_data  in  DATA_WIDTH`: host word.
- `s_ready  out  1`: controller accepts a word.
- `d_w_addr  out  ADDR_WIDTH`, `d_w_dat  out  DATA_WIDTH`, `d_w_enb  out  1`, `d_w_byte_enb  out  4`: data BRAM load port.
- `i_w_addr  out  ADDR_WIDTH`, `i_w_dat  out  DATA_WIDTH`, `i_w_enb  out  1`, `i_w_byte_enb  out  4`: instruction BRAM load port.
- `d_bram_init_done  out  1`: selects core-driven data BRAM writes when 1.
- `core_rst  out  1`: active-high reset to `pc` and `register_file`.
- `pc_stall  out  1`: PC stall.
- `i_r_enb  out  1`: instruction BRAM read enable.
- `rd_enbl  out  1`: register file read enable.
- `state  out  3`: current state (encoding below).
- `cycles_run  out  16`: number of cycles spent in RUN in the current session.

## Operation
- State encoding: IDLE=0, LOAD_D=1, LOAD_I=2, RUN=3, DONE=4. Codes 5–7 are illegal and return to IDLE on the next edge.
- Count handling: counts above `MAX_WORDS` saturate to `MAX_WORDS`. Word index `idx` is 0..count-1, and the BRAM address is `idx<<2`. `idx` never wraps past `MAX_WORDS-1`.
- IDLE:
  - Outputs: `core_rst`=1, `pc_stall`=1, `s_ready`=0.
  - On `start`: latch the counts and budget, clear `idx` and `cycles_run`, then go to LOAD_D.
  - If `d_word_cnt`=0, go straight to LOAD_I; if both counts are 0, go straight to RUN.
- LOAD_D:
  - `s_ready`=1.
  - Each handshake (`s_valid` & `s_ready`) registers one write: `d_w_enb`=1, `d_w_byte_enb`=4'b1111, `d_w_addr`=`idx<<2`, `d_w_dat`=`s_data`.
  - After the handshake for the last word, clear `idx` and go to LOAD_I, or to RUN if `i_word_cnt`=0.
- LOAD_I: same as LOAD_D but on the `i_w_*` port. After the last word, go to RUN.
- RUN:
  - Outputs: `d_bram_init_done`=1, `core_rst`=0, `pc_stall`=0, `i_r_enb`=1, `rd_enbl`=1, `s_ready`=0.
  - `cycles_run` increments each RUN cycle and saturates at 16'hFFFF.
  - Leave for DONE when `halt`=1, or when `run_cycles`≠0 and `cycles_run`==`run_cycles`-1 (so exactly `run_cycles` RUN cycles elapse).
- DONE:
  - Outputs: `pc_stall`=1, `i_r_enb`=0, `core_rst`=0 (registers and memory stay inspectable), `rd_enbl`=1, `d_bram_init_done`=1.
  - `start` begins a new session through the IDLE actions in the same edge; `d_bram_init_done` drops to 0 together with the state change.
- Simultaneous events:
  - `start` outside IDLE/DONE is ignored.
  - `halt` and budget expiry in the same cycle give a single transition to DONE.
  - `s_valid` outside LOAD_D/LOAD_I is ignored and nothing is written.

## Timing
- Reset values (asynchronous `rst_n`=0): `state`=IDLE, `s_ready`=0, all `*_w_enb`=0, all `*_w_byte_enb`=0, all addresses=0, all write data=0, `d_bram_init_done`=0, `core_rst`=1, `pc_stall`=1, `i_r_enb`=0, `rd_enbl`=0, `cycles_run`=0.
- Reset mid-load or mid-run aborts immediately to these values; no partial write is issued after `rst_n` falls.
- All outputs are registered.
- Write latency: a handshake in cycle N produces the BRAM write strobe in cycle N+1, held for exactly one cycle.
- Throughput: one word per cycle while `s_valid` stays high.
- `s_ready` deasserts in the cycle after the last accepted word of the final load phase.
- Phase switch: LOAD_D to LOAD_I adds no bubble, so the first instruction word can be accepted in the cycle after the last data word.
- RUN entry: `core_rst`, `pc_stall` and `d_bram_init_done` change in the same edge. That edge is one cycle after the last instruction write strobe, so the core's first fetch sees the complete program.

## Test plan
- **Basic load and run.** Reset, `start` with `d_word_cnt`=1, `i_word_cnt`=9, `run_cycles`=13; stream data 32'h0000_0000 followed by 9 instruction words back-to-back.
  - Data BRAM word 0 is written at address 0x000.
  - Instruction writes go to 0x000..0x020 on consecutive cycles.
  - RUN lasts exactly 13 cycles, then DONE with `cycles_run`=13.
- **Gapped stream.** `s_valid` toggles every other cycle during a 4-word data load.
  - Exactly 4 strobes at addresses 0x0, 0x4, 0x8, 0xC.
  - No strobe in any cycle without a handshake.
- **Zero counts.** `d_word_cnt`=0, `i_word_cnt`=0 → IDLE→RUN in one edge, with `s_ready` never 1.
- **Halt.** `run_cycles`=0, `halt` pulsed in the 20th RUN cycle → DONE, `pc_stall`=1, `cycles_run`=20. A `start` during RUN before the halt is ignored.
- **Reset mid-load.** `rst_n` low after 3 of 9 instruction words → all outputs take their reset values asynchronously; a new session then reloads from address 0.
- **Saturation.** `d_word_cnt`=1100 → exactly 1024 data words accepted, last address 0xFFC, then LOAD_I.
